// File: rtl/move_request_latch_pkg.sv
`default_nettype none
// ============================================================================
// Package : move_req_pkg
// Brief   : Direction codes, FSM state encoding and code->one-hot helper
//           shared by the movement request latch.
// Rev     : 1.0  initial release
// ============================================================================
package move_req_pkg;

  // 3-bit direction codes; code k drives req_pb[k]
  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_LEFT  = 3'd2;
  localparam logic [2:0] DIR_RIGHT = 3'd3;
  localparam logic [2:0] DIR_DOWN  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } fsm_state_t;

  // Returns bits [4:1] of the request vector; bit 0 of the result is req_pb[1]
  function automatic logic [3:0] dir_onehot(input logic [2:0] code);
    case (code)
      DIR_UP:    dir_onehot = 4'b0001;
      DIR_LEFT:  dir_onehot = 4'b0010;
      DIR_RIGHT: dir_onehot = 4'b0100;
      DIR_DOWN:  dir_onehot = 4'b1000;
      default:   dir_onehot = 4'b0000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pb_debounce.sv
`default_nettype none
// ============================================================================
// Module  : pb_debounce
// Brief   : Two-flop synchroniser plus counter debouncer for one button bit.
//           The level only changes after DEBOUNCE_TICKS consecutive samples
//           disagree with it.
// Rev     : 1.0  initial release
// ============================================================================
module pb_debounce #(
  parameter int DEBOUNCE_TICKS = 2
) (
  input  logic mvmt_clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);

  localparam logic [3:0] TICKS = 4'(DEBOUNCE_TICKS);

  logic       sync1_q;
  logic       sync2_q;
  logic       level_q;
  logic       level_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Count disagreeing samples; commit the new level when the count hits TICKS
  always_comb begin
    level_d = level_q;
    cnt_d   = 4'd0;
    if (sync2_q != level_q) begin
      if ((cnt_q + 4'd1) == TICKS) begin
        level_d = sync2_q;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Synchroniser, counter and debounced level registers
  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/move_request_latch.sv
`default_nettype none
// ============================================================================
// Module  : move_request_latch
// Brief   : Debounces push-buttons, converts presses into direction taps,
//           queues them and presents one stable one-hot request per movement
//           transaction, with hold-to-walk repeat.
// Rev     : 1.0  initial release
// ============================================================================
module move_request_latch
  import move_req_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 2,
  parameter int QUEUE_DEPTH    = 2
) (
  input  logic       mvmt_clk,
  input  logic       reset,
  input  logic       en,
  input  logic [4:0] pb_raw,
  input  logic       move_done,
  output logic [4:0] req_pb,
  output logic       req_valid,
  output logic       queue_overflow
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  logic [4:0]       w_deb;
  logic [4:1]       deb_prev_q;
  logic [4:1]       w_tap;
  logic [4:1]       w_tap_f;
  logic [2:0]       w_tap_code;
  logic             w_tap_vld;

  fsm_state_t       state_q;
  fsm_state_t       state_d;
  logic [2:0]       cur_dir_q;
  logic [2:0]       cur_dir_d;
  logic [3:0]       w_dir_oh;

  logic [2:0]       mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_bypass;
  logic             w_push;
  logic             w_wr;

  generate
    for (genvar i = 0; i < 5; i++) begin : g_pb
      pb_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
      ) u_debounce (
        .mvmt_clk(mvmt_clk),
        .reset   (reset),
        .raw_i   (pb_raw[i]),
        .level_o (w_deb[i])
      );
    end
  endgenerate

  // Previous debounced direction levels for rising-edge tap detection;
  // runs regardless of en so a held button never looks like a new tap
  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) deb_prev_q <= 4'b0000;
    else       deb_prev_q <= w_deb[4:1];
  end

  assign w_tap = w_deb[4:1] & ~deb_prev_q;

  // Cancel opposing pairs, then pick one winner: up > left > right > down
  always_comb begin
    w_tap_f = w_tap;
    if (w_tap[1] && w_tap[4]) begin
      w_tap_f[1] = 1'b0;
      w_tap_f[4] = 1'b0;
    end
    if (w_tap[2] && w_tap[3]) begin
      w_tap_f[2] = 1'b0;
      w_tap_f[3] = 1'b0;
    end
    if (w_tap_f[1])      w_tap_code = DIR_UP;
    else if (w_tap_f[2]) w_tap_code = DIR_LEFT;
    else if (w_tap_f[3]) w_tap_code = DIR_RIGHT;
    else if (w_tap_f[4]) w_tap_code = DIR_DOWN;
    else                 w_tap_code = DIR_NONE;
  end

  assign w_tap_vld = en && (w_tap_code != DIR_NONE);
  assign w_empty   = (cnt_q == '0);
  assign w_full    = (cnt_q == FULL_CNT);
  assign w_dir_oh  = dir_onehot(cur_dir_q);

  // Next-state logic: bypass/pop in IDLE, hold in ISSUE, one-cycle GAP
  always_comb begin
    state_d   = state_q;
    cur_dir_d = cur_dir_q;
    w_pop     = 1'b0;
    w_bypass  = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_tap_vld && w_empty) begin
            w_bypass  = 1'b1;
            cur_dir_d = w_tap_code;
            state_d   = S_ISSUE;
          end else if (!w_empty) begin
            w_pop     = 1'b1;
            cur_dir_d = mem_q[rd_ptr_q];
            state_d   = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (move_done) state_d = S_GAP;
        end
        S_GAP: begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            cur_dir_d = mem_q[rd_ptr_q];
            state_d   = S_ISSUE;
          end else if (|(w_dir_oh & w_deb[4:1])) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A tap not consumed by the bypass goes to the FIFO; a full FIFO only
  // accepts it when a pop frees a slot on the same edge
  assign w_push         = w_tap_vld && !w_bypass;
  assign w_wr           = w_push && (!w_full || w_pop);
  assign queue_overflow = w_push && w_full && !w_pop;

  // FSM state and current direction registers
  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cur_dir_q <= DIR_NONE;
    end else begin
      state_q   <= state_d;
      cur_dir_q <= cur_dir_d;
    end
  end

  // FIFO pointers and occupancy; en low flushes
  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (!en) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_wr)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the count is zero
  always_ff @(posedge mvmt_clk) begin
    if (en && w_wr) mem_q[wr_ptr_q] <= w_tap_code;
  end

  assign req_valid = (state_q == S_ISSUE);
  assign req_pb    = {(req_valid ? w_dir_oh : 4'b0000), w_deb[0]};

endmodule
`default_nettype wire

// File: tb/tb_move_request_latch.sv
`default_nettype none
// ============================================================================
// Module  : tb_move_request_latch
// Brief   : Self-checking bench for move_request_latch (DEBOUNCE_TICKS=2,
//           QUEUE_DEPTH=2): cycle table for hold/glitch/repeat plus directed
//           sequences for taps, overflow, reset and enable.
// Rev     : 1.0  initial release
// ============================================================================
module tb_move_request_latch;

  logic       mvmt_clk = 1'b0;
  logic       reset    = 1'b1;
  logic       en       = 1'b1;
  logic [4:0] pb_raw   = 5'b0;
  logic       move_done = 1'b0;
  logic [4:0] req_pb;
  logic       req_valid;
  logic       queue_overflow;

  int n_cmp = 0;
  int n_err = 0;
  int ovf_cnt = 0;

  typedef struct {
    logic [4:0] pb;
    logic       md;
    logic [4:0] exp_pb;
    logic       exp_vld;
  } vec_t;

  vec_t tbl [19];

  move_request_latch #(
    .DEBOUNCE_TICKS(2),
    .QUEUE_DEPTH   (2)
  ) dut (
    .mvmt_clk      (mvmt_clk),
    .reset         (reset),
    .en            (en),
    .pb_raw        (pb_raw),
    .move_done     (move_done),
    .req_pb        (req_pb),
    .req_valid     (req_valid),
    .queue_overflow(queue_overflow)
  );

  always #5 mvmt_clk = ~mvmt_clk;

  // Count overflow pulses, sampled mid-cycle
  always @(negedge mvmt_clk) begin
    if (queue_overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge mvmt_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    en        = 1'b1;
    pb_raw    = 5'b0;
    move_done = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic pulse_md();
    move_done = 1'b1;
    step(1);
    move_done = 1'b0;
  endtask

  // Three-cycle raw press then quiet long enough for the level to fall
  task automatic tap(input logic [4:0] bits);
    pb_raw = bits;
    step(3);
    pb_raw = 5'b0;
    step(5);
  endtask

  function automatic vec_t mk(input logic [4:0] pb, input logic md,
                              input logic [4:0] ep, input logic ev);
    vec_t v;
    v.pb = pb; v.md = md; v.exp_pb = ep; v.exp_vld = ev;
    return v;
  endfunction

  initial begin
    int base;
    logic seen;

    // Hold RIGHT, glitch low during ISSUE, repeat after move_done, release
    tbl[0]  = mk(5'b01000, 1'b0, 5'b00000, 1'b0);
    tbl[1]  = mk(5'b01000, 1'b0, 5'b00000, 1'b0);
    tbl[2]  = mk(5'b01000, 1'b0, 5'b00000, 1'b0);
    tbl[3]  = mk(5'b01000, 1'b0, 5'b00000, 1'b0);
    tbl[4]  = mk(5'b01000, 1'b0, 5'b01000, 1'b1);
    tbl[5]  = mk(5'b00000, 1'b0, 5'b01000, 1'b1);
    tbl[6]  = mk(5'b01000, 1'b0, 5'b01000, 1'b1);
    tbl[7]  = mk(5'b01000, 1'b0, 5'b01000, 1'b1);
    tbl[8]  = mk(5'b01000, 1'b0, 5'b01000, 1'b1);
    tbl[9]  = mk(5'b01000, 1'b0, 5'b01000, 1'b1);
    tbl[10] = mk(5'b01000, 1'b1, 5'b00000, 1'b0);
    tbl[11] = mk(5'b01000, 1'b0, 5'b01000, 1'b1);
    tbl[12] = mk(5'b00000, 1'b0, 5'b01000, 1'b1);
    tbl[13] = mk(5'b00000, 1'b0, 5'b01000, 1'b1);
    tbl[14] = mk(5'b00000, 1'b0, 5'b01000, 1'b1);
    tbl[15] = mk(5'b00000, 1'b0, 5'b01000, 1'b1);
    tbl[16] = mk(5'b00000, 1'b1, 5'b00000, 1'b0);
    tbl[17] = mk(5'b00000, 1'b0, 5'b00000, 1'b0);
    tbl[18] = mk(5'b00000, 1'b0, 5'b00000, 1'b0);

    do_reset();
    check("reset_req_pb", {3'b0, req_pb}, 8'h00);
    check("reset_req_valid", {7'b0, req_valid}, 8'h00);
    check("reset_overflow", {7'b0, queue_overflow}, 8'h00);

    for (int i = 0; i < 19; i++) begin
      pb_raw    = tbl[i].pb;
      move_done = tbl[i].md;
      step(1);
      check($sformatf("tbl%0d_req_pb", i), {3'b0, req_pb}, {3'b0, tbl[i].exp_pb});
      check($sformatf("tbl%0d_valid", i), {7'b0, req_valid}, {7'b0, tbl[i].exp_vld});
      check($sformatf("tbl%0d_ovf", i), {7'b0, queue_overflow}, 8'h00);
    end
    move_done = 1'b0;

    // Centre button: passed through after two sync edges plus two debounce edges
    do_reset();
    pb_raw = 5'b00001;
    step(3);
    check("centre_before", {3'b0, req_pb}, 8'h00);
    step(1);
    check("centre_after", {3'b0, req_pb}, 8'h01);
    check("centre_no_valid", {7'b0, req_valid}, 8'h00);

    // One-cycle UP pulse is filtered out
    do_reset();
    pb_raw = 5'b00010;
    step(1);
    pb_raw = 5'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (req_valid !== 1'b0) seen = 1'b1;
    end
    check("short_pulse_ignored", {7'b0, seen}, 8'h00);

    // Three-cycle UP pulse: one request, one GAP, then IDLE
    pb_raw = 5'b00010;
    step(3);
    pb_raw = 5'b0;
    step(2);
    check("up_issue", {3'b0, req_pb}, 8'h02);
    step(4);
    pulse_md();
    check("up_gap", {3'b0, req_pb}, 8'h00);
    step(1);
    check("up_idle", {7'b0, req_valid}, 8'h00);
    step(3);
    check("up_stays_idle", {7'b0, req_valid}, 8'h00);

    // Hold DOWN: each move_done yields exactly one zero cycle then re-issue
    do_reset();
    pb_raw = 5'b10000;
    step(5);
    check("down_issue0", {3'b0, req_pb}, 8'h10);
    for (int k = 0; k < 3; k++) begin
      step(2);
      pulse_md();
      check($sformatf("down_gap%0d", k), {3'b0, req_pb}, 8'h00);
      step(1);
      check($sformatf("down_repeat%0d", k), {3'b0, req_pb}, 8'h10);
    end
    pb_raw = 5'b0;
    step(6);
    pulse_md();
    check("down_final_gap", {3'b0, req_pb}, 8'h00);
    step(1);
    check("down_idle", {7'b0, req_valid}, 8'h00);
    step(3);
    check("down_stays_idle", {7'b0, req_valid}, 8'h00);

    // Opposing UP+DOWN cancel; UP+LEFT+RIGHT gives UP only
    do_reset();
    pb_raw = 5'b10010;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (req_valid !== 1'b0) seen = 1'b1;
    end
    check("opposing_cancel", {7'b0, seen}, 8'h00);
    pb_raw = 5'b0;
    step(6);
    pb_raw = 5'b01110;
    step(5);
    check("priority_up", {3'b0, req_pb}, 8'h02);
    pb_raw = 5'b0;
    step(6);
    pulse_md();
    check("priority_gap", {3'b0, req_pb}, 8'h00);
    step(1);
    check("losers_not_queued", {7'b0, req_valid}, 8'h00);
    step(3);
    check("losers_still_idle", {7'b0, req_valid}, 8'h00);

    // Queue LEFT, RIGHT during ISSUE(UP); DOWN overflows once
    do_reset();
    pb_raw = 5'b00010;
    step(5);
    pb_raw = 5'b0;
    check("q_issue_up", {3'b0, req_pb}, 8'h02);
    base = ovf_cnt;
    tap(5'b00100);
    tap(5'b01000);
    check("q_no_ovf_yet", ovf_cnt - base, 8'h00);
    tap(5'b10000);
    check("q_overflow_once", ovf_cnt - base, 8'h01);
    check("q_still_up", {3'b0, req_pb}, 8'h02);
    pulse_md();
    check("q_gap1", {3'b0, req_pb}, 8'h00);
    step(1);
    check("q_left", {3'b0, req_pb}, 8'h04);
    step(2);
    pulse_md();
    check("q_gap2", {3'b0, req_pb}, 8'h00);
    step(1);
    check("q_right", {3'b0, req_pb}, 8'h08);
    step(2);
    pulse_md();
    check("q_gap3", {3'b0, req_pb}, 8'h00);
    step(1);
    check("q_idle", {7'b0, req_valid}, 8'h00);
    step(3);
    check("q_down_dropped", {7'b0, req_valid}, 8'h00);

    // Asynchronous reset during ISSUE clears outputs without an edge
    do_reset();
    pb_raw = 5'b01000;
    step(5);
    check("rst_pre_issue", {3'b0, req_pb}, 8'h08);
    reset = 1'b1;
    #2;
    check("rst_async_req_pb", {3'b0, req_pb}, 8'h00);
    check("rst_async_valid", {7'b0, req_valid}, 8'h00);
    step(1);
    pb_raw = 5'b0;
    reset = 1'b0;
    step(2);

    // en low flushes a two-entry queue on the next edge
    pb_raw = 5'b00010;
    step(5);
    pb_raw = 5'b0;
    check("en_issue_up", {3'b0, req_pb}, 8'h02);
    tap(5'b00100);
    tap(5'b01000);
    en = 1'b0;
    step(1);
    check("en_low_valid", {7'b0, req_valid}, 8'h00);
    check("en_low_req_pb", {3'b0, req_pb}, 8'h00);
    step(3);
    en = 1'b1;
    step(6);
    check("en_fifo_flushed", {7'b0, req_valid}, 8'h00);

    // Button held across en rising gives no request until re-press
    en = 1'b0;
    pb_raw = 5'b00100;
    step(8);
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (req_valid !== 1'b0) seen = 1'b1;
    end
    check("en_rise_held_no_tap", {7'b0, seen}, 8'h00);
    pb_raw = 5'b0;
    step(6);
    pb_raw = 5'b00100;
    step(5);
    check("en_repress_left", {3'b0, req_pb}, 8'h04);
    pb_raw = 5'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
